// File: rtl/ip_ingress_buffer.sv
// Store-and-forward ingress buffer between an IP flit source and a router local port.
// Packets longer than MAX_PKT_FLITS are truncated (last flit forced) and the remainder dropped.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ACCEPT | flits are written to the FIFO, len tracks index in packet
// ST_DROP   | tail of an over-long packet is consumed and discarded

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ip_ingress_buffer #(
    parameter int DEPTH         = 16,
    parameter int MAX_PKT_FLITS = 8
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     Valid_in,
    input  logic [`DATA_WIDTH-1:0]   Data_in,
    input  logic                     Last_in,
    output logic                     Ready_in,
    output logic                     Valid_out,
    output logic [`DATA_WIDTH-1:0]   Data_out,
    output logic                     Last_out,
    input  logic                     Ready_out,
    output logic [$clog2(DEPTH):0]   flit_cnt,
    output logic [$clog2(DEPTH):0]   pkt_cnt,
    output logic [9:0]               rx_cnt,
    output logic [9:0]               tx_cnt,
    output logic                     len_err
);

    localparam int W  = `DATA_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(MAX_PKT_FLITS);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PKT_FLITS - 1);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } in_state_e;

    in_state_e       in_state_q, in_state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   flit_cnt_q, flit_cnt_d;
    logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic [9:0]      rx_cnt_q, rx_cnt_d;
    logic [9:0]      tx_cnt_q, tx_cnt_d;
    logic            len_err_q, len_err_d;

    logic [W-1:0]    mem_data [DEPTH];
    logic            mem_last [DEPTH];

    logic            accept;
    logic            push;
    logic            pop;
    logic            len_at_max;
    logic            store_last;
    logic            pop_last;

    assign Valid_out  = (pkt_cnt_q != '0);
    assign Data_out   = mem_data[rd_ptr_q];
    assign Last_out   = Valid_out && mem_last[rd_ptr_q];
    assign pop        = Valid_out && Ready_out;
    assign pop_last   = pop && Last_out;
    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    assign Ready_in   = (in_state_q == ST_DROP) || (flit_cnt_q < DEPTH_C) || pop;
    assign accept     = Valid_in && Ready_in;
    assign push       = accept && (in_state_q == ST_ACCEPT);
    assign len_at_max = (len_q == LEN_MAX);
    assign store_last = Last_in || len_at_max;

    assign flit_cnt = flit_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign rx_cnt   = rx_cnt_q;
    assign tx_cnt   = tx_cnt_q;
    assign len_err  = len_err_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            in_state_q <= ST_ACCEPT;
        end else begin
            in_state_q <= in_state_d;
        end
    end

    always_comb begin
        in_state_d = in_state_q;
        case (in_state_q)
            ST_ACCEPT: if (accept && !Last_in && len_at_max) in_state_d = ST_DROP;
            ST_DROP:   if (accept && Last_in)                in_state_d = ST_ACCEPT;
            default:   in_state_d = ST_ACCEPT;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        len_d      = len_q;
        rx_cnt_d   = rx_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        len_err_d  = len_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (store_last) begin
                len_d    = '0;
                rx_cnt_d = rx_cnt_q + 10'd1;
            end else begin
                len_d = len_q + LW'(1);
            end
            if (!Last_in && len_at_max) len_err_d = 1'b1;
        end
        if (accept && (in_state_q == ST_DROP) && Last_in) len_d = '0;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (Last_out) tx_cnt_d = tx_cnt_q + 10'd1;
        end

        case ({push, pop})
            2'b10:   flit_cnt_d = flit_cnt_q + CW'(1);
            2'b01:   flit_cnt_d = flit_cnt_q - CW'(1);
            default: flit_cnt_d = flit_cnt_q;
        endcase

        case ({push && store_last, pop_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            len_q      <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            len_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            len_q      <= len_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    // Storage is deliberately left unreset; pkt_cnt gates everything visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= Data_in;
            mem_last[wr_ptr_q] <= store_last;
        end
    end

endmodule

// File: tb/tb_ip_ingress_buffer.sv
// Randomized and directed bench for ip_ingress_buffer, checked against a packet-queue model.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_ip_ingress_buffer;

    localparam int W     = `DATA_WIDTH;
    localparam int DEPTH = 16;
    localparam int MAXF  = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           nreset;
    logic           Valid_in;
    logic [W-1:0]   Data_in;
    logic           Last_in;
    logic           Ready_in;
    logic           Valid_out;
    logic [W-1:0]   Data_out;
    logic           Last_out;
    logic           Ready_out;
    logic [CW-1:0]  flit_cnt;
    logic [CW-1:0]  pkt_cnt;
    logic [9:0]     rx_cnt;
    logic [9:0]     tx_cnt;
    logic           len_err;

    ip_ingress_buffer #(.DEPTH(DEPTH), .MAX_PKT_FLITS(MAXF)) dut (
        .clk(clk), .nreset(nreset),
        .Valid_in(Valid_in), .Data_in(Data_in), .Last_in(Last_in), .Ready_in(Ready_in),
        .Valid_out(Valid_out), .Data_out(Data_out), .Last_out(Last_out), .Ready_out(Ready_out),
        .flit_cnt(flit_cnt), .pkt_cnt(pkt_cnt), .rx_cnt(rx_cnt), .tx_cnt(tx_cnt), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of stored {last, data} words plus packet-framing state.
    logic [W:0]   q[$];
    bit           m_drop;
    int           m_len;
    int           m_rx, m_tx;
    bit           m_err;

    bit           exp_ready, exp_valid, exp_last;
    logic [W-1:0] exp_data;
    int           exp_flits, exp_pkts;

    task automatic model_reset();
        q.delete();
        m_drop = 0; m_len = 0; m_rx = 0; m_tx = 0; m_err = 0;
    endtask

    // Drive inputs for the coming edge and compute the model's view of this cycle.
    task automatic apply(input logic v, input logic [W-1:0] d, input logic l, input logic ro);
        Valid_in = v; Data_in = d; Last_in = l; Ready_out = ro;
        #1;
        exp_pkts = 0;
        foreach (q[i]) if (q[i][W]) exp_pkts++;
        exp_flits = q.size();
        exp_valid = (exp_pkts != 0);
        exp_ready = m_drop || (exp_flits < DEPTH) || (exp_valid && ro);
        exp_data  = exp_valid ? q[0][W-1:0] : '0;
        exp_last  = exp_valid ? q[0][W] : 1'b0;
    endtask

    task automatic tick();
        bit acc, pop, forced;
        @(posedge clk);
        acc = Valid_in && exp_ready;
        pop = exp_valid && Ready_out;
        if (pop) begin
            if (q[0][W]) m_tx = (m_tx + 1) % 1024;
            void'(q.pop_front());
        end
        if (acc) begin
            if (!m_drop) begin
                forced = !Last_in && (m_len == MAXF - 1);
                q.push_back({Last_in || forced, Data_in});
                if (Last_in || forced) begin
                    m_rx  = (m_rx + 1) % 1024;
                    m_len = 0;
                end else begin
                    m_len++;
                end
                if (forced) begin
                    m_err  = 1;
                    m_drop = 1;
                end
            end else if (Last_in) begin
                m_drop = 0;
                m_len  = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        Valid_in = 1'b0; Data_in = '0; Last_in = 1'b0; Ready_out = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        checks++;
        if (Valid_out !== 1'b0 || Last_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: Valid_out=%b Last_out=%b required 0 0", Valid_out, Last_out);
        end
        checks++;
        if (flit_cnt !== '0 || pkt_cnt !== '0 || rx_cnt !== '0 || tx_cnt !== '0 || len_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_counters: flit=%0d pkt=%0d rx=%0d tx=%0d err=%b required all 0",
                     flit_cnt, pkt_cnt, rx_cnt, tx_cnt, len_err);
        end
        @(negedge clk);
        nreset = 1'b1;
        apply(0, '0, 0, 0);
        checks++;
        if (Ready_in !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_in: got %b required 1", Ready_in);
        end
    endtask

    task automatic test_single_packet();
        for (int k = 0; k < 4; k++) begin
            apply(1, W'(32'h0202_0000 + k), (k == 3), 1);
            checks++;
            if (Valid_out !== exp_valid || Ready_in !== exp_ready) begin
                failures++;
                $display("FAIL single_fill: Valid_out=%b Ready_in=%b required %b %b",
                         Valid_out, Ready_in, exp_valid, exp_ready);
            end
            tick();
        end
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            apply(0, '0, 0, 1);
            checks++;
            if (Valid_out !== exp_valid || (exp_valid && (Data_out !== exp_data || Last_out !== exp_last))) begin
                failures++;
                $display("FAIL single_drain: valid=%b data=%h last=%b required %b %h %b",
                         Valid_out, Data_out, Last_out, exp_valid, exp_data, exp_last);
            end
            tick();
        end
        apply(0, '0, 0, 1);
        checks++;
        if (rx_cnt !== 10'd1 || tx_cnt !== 10'd1 || flit_cnt !== '0) begin
            failures++;
            $display("FAIL single_counts: rx=%0d tx=%0d flit=%0d required 1 1 0", rx_cnt, tx_cnt, flit_cnt);
        end
    endtask

    task automatic test_backpressure();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                apply(1, W'($urandom()), (k == 3), 0);
                checks++;
                if (Ready_in !== exp_ready || Valid_out !== exp_valid) begin
                    failures++;
                    $display("FAIL bp_fill: Ready_in=%b Valid_out=%b required %b %b",
                             Ready_in, Valid_out, exp_ready, exp_valid);
                end
                tick();
            end
        end
        apply(1, W'($urandom()), 0, 0);
        checks++;
        if (Ready_in !== 1'b0 || flit_cnt !== CW'(16) || pkt_cnt !== CW'(4)) begin
            failures++;
            $display("FAIL bp_full: Ready_in=%b flit=%0d pkt=%0d required 0 16 4", Ready_in, flit_cnt, pkt_cnt);
        end
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            apply(0, '0, 0, 1);
            checks++;
            if (Valid_out !== exp_valid || (exp_valid && (Data_out !== exp_data || Last_out !== exp_last))) begin
                failures++;
                $display("FAIL bp_drain: valid=%b data=%h last=%b required %b %h %b",
                         Valid_out, Data_out, Last_out, exp_valid, exp_data, exp_last);
            end
            tick();
        end
        apply(0, '0, 0, 0);
        checks++;
        if (Ready_in !== 1'b1 || flit_cnt !== '0 || tx_cnt !== 10'd5) begin
            failures++;
            $display("FAIL bp_empty: Ready_in=%b flit=%0d tx=%0d required 1 0 5", Ready_in, flit_cnt, tx_cnt);
        end
    endtask

    task automatic test_len_err();
        int fwd = 0;
        for (int k = 0; k < 13; k++) begin
            apply(1, W'(32'hA000_0000 + k), (k == 9 || k == 12), 1);
            if (Valid_out && Ready_out) fwd++;
            checks++;
            if (Valid_out !== exp_valid || (exp_valid && (Data_out !== exp_data || Last_out !== exp_last))) begin
                failures++;
                $display("FAIL lenerr_stream: valid=%b data=%h last=%b required %b %h %b",
                         Valid_out, Data_out, Last_out, exp_valid, exp_data, exp_last);
            end
            tick();
        end
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            apply(0, '0, 0, 1);
            if (Valid_out && Ready_out) fwd++;
            checks++;
            if (Valid_out !== exp_valid || (exp_valid && (Data_out !== exp_data || Last_out !== exp_last))) begin
                failures++;
                $display("FAIL lenerr_drain: valid=%b data=%h last=%b required %b %h %b",
                         Valid_out, Data_out, Last_out, exp_valid, exp_data, exp_last);
            end
            tick();
        end
        apply(0, '0, 0, 0);
        checks++;
        if (len_err !== 1'b1 || fwd != 11 || rx_cnt !== 10'd7) begin
            failures++;
            $display("FAIL lenerr_result: len_err=%b forwarded=%0d rx=%0d required 1 11 7", len_err, fwd, rx_cnt);
        end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 16; k++) begin
            apply(1, W'(32'hF000_0000 + k), (k % 4 == 3), 0);
            tick();
        end
        apply(1, W'(32'hF000_0100), 0, 1);
        checks++;
        if (Ready_in !== 1'b1 || Valid_out !== 1'b1 || Data_out !== exp_data) begin
            failures++;
            $display("FAIL full_pushpop: Ready_in=%b Valid_out=%b data=%h required 1 1 %h",
                     Ready_in, Valid_out, Data_out, exp_data);
        end
        tick();
        apply(0, '0, 0, 0);
        checks++;
        if (flit_cnt !== CW'(16) || pkt_cnt !== CW'(4)) begin
            failures++;
            $display("FAIL full_count: flit=%0d pkt=%0d required 16 4", flit_cnt, pkt_cnt);
        end
        for (int k = 1; k < 4; k++) begin
            apply(1, W'(32'hF000_0100 + k), (k == 3), 1);
            tick();
        end
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            apply(0, '0, 0, 1);
            checks++;
            if (Valid_out !== exp_valid || (exp_valid && (Data_out !== exp_data || Last_out !== exp_last))) begin
                failures++;
                $display("FAIL full_drain: valid=%b data=%h last=%b required %b %h %b",
                         Valid_out, Data_out, Last_out, exp_valid, exp_data, exp_last);
            end
            tick();
        end
        apply(0, '0, 0, 0);
        checks++;
        if (flit_cnt !== '0 || tx_cnt !== m_tx[9:0]) begin
            failures++;
            $display("FAIL full_empty: flit=%0d tx=%0d required 0 %0d", flit_cnt, tx_cnt, m_tx);
        end
    endtask

    task automatic test_random();
        logic v, l, ro;
        for (int c = 0; c < 1500; c++) begin
            v  = ($urandom_range(3) != 0);
            l  = ($urandom_range(3) == 0);
            ro = (c % 200 < 100) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            apply(v, W'($urandom()), l, ro);
            checks++;
            if (Ready_in !== exp_ready || Valid_out !== exp_valid) begin
                failures++;
                $display("FAIL rand_handshake c=%0d: Ready_in=%b Valid_out=%b required %b %b",
                         c, Ready_in, Valid_out, exp_ready, exp_valid);
            end
            checks++;
            if (exp_valid && (Data_out !== exp_data || Last_out !== exp_last)) begin
                failures++;
                $display("FAIL rand_data c=%0d: data=%h last=%b required %h %b", c, Data_out, Last_out, exp_data, exp_last);
            end
            checks++;
            if (flit_cnt !== CW'(exp_flits) || pkt_cnt !== CW'(exp_pkts)) begin
                failures++;
                $display("FAIL rand_occupancy c=%0d: flit=%0d pkt=%0d required %0d %0d",
                         c, flit_cnt, pkt_cnt, exp_flits, exp_pkts);
            end
            checks++;
            if (rx_cnt !== m_rx[9:0] || tx_cnt !== m_tx[9:0] || len_err !== m_err) begin
                failures++;
                $display("FAIL rand_stats c=%0d: rx=%0d tx=%0d err=%b required %0d %0d %b",
                         c, rx_cnt, tx_cnt, len_err, m_rx, m_tx, m_err);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_packet();
        for (int k = 0; k < 2; k++) begin
            apply(1, W'(32'hC0DE_0000 + k), 0, 1);
            checks++;
            if (Valid_out !== 1'b0) begin
                failures++;
                $display("FAIL midrst_partial: Valid_out=%b required 0", Valid_out);
            end
            tick();
        end
        nreset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (flit_cnt !== '0 || Valid_out !== 1'b0 || Last_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: flit=%0d Valid_out=%b Last_out=%b required 0 0 0", flit_cnt, Valid_out, Last_out);
        end
        @(negedge clk);
        nreset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            apply(0, '0, 0, 1);
            checks++;
            if (Valid_out !== 1'b0 || flit_cnt !== '0) begin
                failures++;
                $display("FAIL midrst_after c=%0d: Valid_out=%b flit=%0d required 0 0", c, Valid_out, flit_cnt);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            apply(1, W'(32'hBEEF_0000 + k), (k == 1), 1);
            tick();
        end
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            apply(0, '0, 0, 1);
            checks++;
            if (Valid_out !== exp_valid || (exp_valid && (Data_out !== exp_data || Last_out !== exp_last))) begin
                failures++;
                $display("FAIL midrst_next: valid=%b data=%h last=%b required %b %h %b",
                         Valid_out, Data_out, Last_out, exp_valid, exp_data, exp_last);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_backpressure();
        test_len_err();
        test_full_push_pop();
        test_random();
        apply(1, W'($urandom()), 1, 1);
        tick();
        for (int c = 0; c < 60 && q.size() > 0; c++) begin
            apply(0, '0, 0, 1);
            checks++;
            if (Valid_out !== exp_valid || (exp_valid && (Data_out !== exp_data || Last_out !== exp_last))) begin
                failures++;
                $display("FAIL rand_drain: valid=%b data=%h last=%b required %b %h %b",
                         Valid_out, Data_out, Last_out, exp_valid, exp_data, exp_last);
            end
            tick();
        end
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
